// File: rtl/multiplicador_secuencial_pkg.sv
// Shared defaults and FSM encoding for the sequential signed fixed-point multiplier.
package multiplicador_secuencial_pkg;

    localparam int unsigned ANCHO_DEF      = 16;
    localparam int unsigned RESOLUCION_DEF = 8;
    localparam int unsigned DOBLEANCHO_DEF = 2 * ANCHO_DEF;

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        CALCULO = 2'd1,
        AJUSTE  = 2'd2
    } estado_e;

endpackage

// File: rtl/multiplicador_secuencial_valor_absoluto.sv
// Two's-complement magnitude; -2^(W-1) maps to 2^(W-1), which fits as unsigned.
module multiplicador_secuencial_valor_absoluto #(
    parameter int unsigned ANCHO = 16
) (
    input  logic [ANCHO-1:0] valor,
    output logic [ANCHO-1:0] magnitud_c
);

    assign magnitud_c = valor[ANCHO-1] ? (~valor + ANCHO'(1)) : valor;

endmodule

// File: rtl/multiplicador_secuencial.sv
// Radix-2 shift-add signed multiplier: sign-magnitude core, one multiplier bit per clock,
// deterministic ANCHO+2 cycle latency with a start/ready/valid handshake.
module multiplicador_secuencial
    import multiplicador_secuencial_pkg::*;
#(
    parameter int unsigned ANCHO = ANCHO_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 inicio,
    input  logic [ANCHO-1:0]     multiplicando,
    input  logic [ANCHO-1:0]     multiplicador,
    output logic                 listo,
    output logic [2*ANCHO-1:0]   producto,
    output logic                 valido
);

    localparam int unsigned DOBLEANCHO = 2 * ANCHO;
    localparam int unsigned CNT_W      = $clog2(ANCHO + 1);

    estado_e                estado_q, estado_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DOBLEANCHO-1:0]  mcand_q, mcand_d;
    logic [ANCHO-1:0]       mplier_q, mplier_d;
    logic [DOBLEANCHO-1:0]  acc_q, acc_d;
    logic                   signo_q, signo_d;
    logic [DOBLEANCHO-1:0]  producto_q, producto_d;
    logic                   valido_q, valido_d;
    logic                   listo_q, listo_d;
    logic [ANCHO-1:0]       mag_a_c, mag_b_c;

    multiplicador_secuencial_valor_absoluto #(.ANCHO(ANCHO)) u_abs_a (
        .valor      (multiplicando),
        .magnitud_c (mag_a_c)
    );

    multiplicador_secuencial_valor_absoluto #(.ANCHO(ANCHO)) u_abs_b (
        .valor      (multiplicador),
        .magnitud_c (mag_b_c)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado_q   <= REPOSO;
            cnt_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            signo_q    <= 1'b0;
            producto_q <= '0;
            valido_q   <= 1'b0;
            listo_q    <= 1'b1;
        end else begin
            estado_q   <= estado_d;
            cnt_q      <= cnt_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            signo_q    <= signo_d;
            producto_q <= producto_d;
            valido_q   <= valido_d;
            listo_q    <= listo_d;
        end
    end

    // Next-state and datapath control
    always_comb begin
        estado_d   = estado_q;
        cnt_d      = cnt_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        signo_d    = signo_q;
        producto_d = producto_q;
        valido_d   = 1'b0;

        case (estado_q)
            REPOSO: begin
                if (inicio) begin
                    mcand_d  = DOBLEANCHO'(mag_a_c);
                    mplier_d = mag_b_c;
                    signo_d  = multiplicando[ANCHO-1] ^ multiplicador[ANCHO-1];
                    acc_d    = '0;
                    cnt_d    = '0;
                    estado_d = CALCULO;
                end
            end
            CALCULO: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ANCHO - 1)) begin
                    estado_d = AJUSTE;
                end
            end
            AJUSTE: begin
                producto_d = signo_q ? (~acc_q + DOBLEANCHO'(1)) : acc_q;
                valido_d   = 1'b1;
                estado_d   = REPOSO;
            end
            default: begin
                estado_d = REPOSO;
            end
        endcase

        // Ready is registered: it reflects the state being entered.
        listo_d = (estado_d == REPOSO);
    end

    assign listo    = listo_q;
    assign producto = producto_q;
    assign valido   = valido_q;

endmodule

// File: tb/tb_multiplicador_secuencial.sv
// Directed and random checks for the sequential signed multiplier.
module tb_multiplicador_secuencial;

    localparam int unsigned ANCHO = 16;
    localparam int unsigned LAT   = ANCHO + 1;

    logic                 clk;
    logic                 reset_n;
    logic                 inicio;
    logic [ANCHO-1:0]     multiplicando;
    logic [ANCHO-1:0]     multiplicador;
    logic                 listo;
    logic [2*ANCHO-1:0]   producto;
    logic                 valido;

    int unsigned n_vec;
    int unsigned n_err;

    multiplicador_secuencial #(.ANCHO(ANCHO)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .inicio        (inicio),
        .multiplicando (multiplicando),
        .multiplicador (multiplicador),
        .listo         (listo),
        .producto      (producto),
        .valido        (valido)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one operation from a point just after an edge, then wait for valido.
    // Leaves time at #1 after the valido edge so a following call runs back-to-back.
    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp, input bit hold_inicio);
        int unsigned n;
        int unsigned low;
        int unsigned changes;
        logic [31:0] prev;
        inicio        = 1'b1;
        multiplicando = a;
        multiplicador = b;
        prev          = producto;
        @(posedge clk);
        #1;
        if (!hold_inicio) inicio = 1'b0;
        n       = 0;
        low     = 0;
        changes = 0;
        while (!valido && n < 40) begin
            if (!listo) low++;
            if (producto !== prev) changes++;
            if (hold_inicio) begin
                multiplicando = 16'h7FFF - 16'(n);
                multiplicador = 16'h1234 + 16'(n);
                if (n == 10) inicio = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, " latency"}, n, LAT);
        chk({tag, " listo_low"}, low, LAT);
        chk({tag, " held"}, changes, 0);
        chk({tag, " producto"}, producto, exp);
        chk({tag, " listo_at_valido"}, 32'(listo), 32'd1);
    endtask

    task automatic idle_check(input string tag);
        logic [31:0] held;
        held   = producto;
        inicio = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, " valido_single"}, 32'(valido), 32'd0);
        chk({tag, " producto_hold"}, producto, held);
    endtask

    initial begin
        int unsigned pulses;
        logic [15:0] ra, rb;
        logic [31:0] rexp;

        n_vec         = 0;
        n_err         = 0;
        reset_n       = 1'b0;
        inicio        = 1'b0;
        multiplicando = '0;
        multiplicador = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst producto", producto, 32'h0);
        chk("rst valido", 32'(valido), 32'd0);
        chk("rst listo", 32'(listo), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        do_op("1.5x2.0", 16'h0180, 16'h0200, 32'h0003_0000, 1'b0);
        idle_check("1.5x2.0");
        do_op("-1.5x2.0", 16'hFE80, 16'h0200, 32'hFFFD_0000, 1'b0);
        idle_check("-1.5x2.0");
        do_op("2.0x-1.5", 16'h0200, 16'hFE80, 32'hFFFD_0000, 1'b0);
        do_op("-1.5x-2.0", 16'hFE80, 16'hFE00, 32'h0003_0000, 1'b0);
        do_op("min_x_min", 16'h8000, 16'h8000, 32'h4000_0000, 1'b0);
        do_op("max_x_min", 16'h7FFF, 16'h8000, 32'hC000_8000, 1'b0);
        do_op("zero_x_min", 16'h0000, 16'h8000, 32'h0000_0000, 1'b0);
        do_op("neg1_x_1", 16'hFF00, 16'h0100, 32'hFFFF_0000, 1'b0);
        idle_check("neg1_x_1");

        // inicio held high while busy: later operands must be ignored
        do_op("hold_inicio", 16'h0180, 16'h0200, 32'h0003_0000, 1'b1);
        idle_check("hold_inicio");

        // back-to-back: second start issued in the valido cycle
        do_op("b2b_first", 16'h0300, 16'h0300, 32'h0009_0000, 1'b0);
        do_op("b2b_second", 16'hFD00, 16'h0100, 32'hFFFD_0000, 1'b0);
        idle_check("b2b_second");

        // asynchronous reset mid-calculation
        inicio        = 1'b1;
        multiplicando = 16'h0180;
        multiplicador = 16'h0200;
        @(posedge clk);
        #1;
        inicio = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("midrst producto", producto, 32'h0);
        chk("midrst valido", 32'(valido), 32'd0);
        chk("midrst listo", 32'(listo), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        pulses  = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (valido) pulses++;
        end
        chk("midrst no_valido", pulses, 0);

        // random sweep, issued back-to-back
        for (int i = 0; i < 1000; i++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rexp = 32'($signed(ra) * $signed(rb));
            do_op("rand", ra, rb, rexp, 1'b0);
        end
        idle_check("rand_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multiplicador_secuencial.md
Name: multiplicador_secuencial

Overview:
Sequential signed fixed-point multiplier that produces the full-precision double-width product consumed by the truncation/saturation stage (Truncador2) directly downstream.
Operands are two's-complement words in Q(ANCHO-RESOLUCION-1).RESOLUCION format. The product is in Q(2·ANCHO-2·RESOLUCION-1).(2·RESOLUCION) format, matching the DOBLEANCHO bit layout the truncator slices.
The multiplier uses radix-2 shift-add, one operand bit per clock, and a start/ready/valid handshake. This trades latency for area in the filter datapath.

Parameters:
ANCHO, 16, operand width in bits (mirrors `ancho)
RESOLUCION, 8, fractional bits per operand (mirrors `resolucion)
DOBLEANCHO, 2*ANCHO, product width (mirrors `dobleancho); not independently overridable

Ports:
clk  input  1  system clock, rising-edge
reset_n  input  1  asynchronous active-low reset
inicio  input  1  start request; sampled only while listo=1
multiplicando  input  ANCHO  signed operand A, sampled with inicio
multiplicador  input  ANCHO  signed operand B, sampled with inicio
listo  output  1  block idle, will accept inicio this cycle
producto  output  DOBLEANCHO  signed product, registered, held until the next result
valido  output  1  one-cycle pulse: producto updated this cycle

Behaviour:
- Reset (reset_n=0, asynchronous, any state): state=REPOSO, producto=0, valido=0, listo=1, counter=0, internal registers=0. Reset mid-calculation aborts it; no valido is issued.
- States:
  - REPOSO: listo=1. Edge with inicio=1 latches |A|, |B|, signo=A[ANCHO-1]^B[ANCHO-1]; clears accumulator and counter; goes to CALCULO.
  - CALCULO: listo=0. Each edge: if multiplier LSB=1, add the multiplicand (zero-extended to DOBLEANCHO) to the accumulator; shift the multiplicand left 1 and the multiplier right 1; counter++. After the ANCHO-th edge, goes to AJUSTE.
  - AJUSTE: listo=0. Edge loads producto = signo ? -acc : acc, sets valido=1, goes to REPOSO.
- Latency: inicio sampled at edge 0 → producto/valido visible after edge ANCHO+1. Throughput is one product per ANCHO+2 cycles.
- valido lasts exactly one cycle. producto holds its value until the next AJUSTE or reset.
- Magnitudes are ANCHO-bit unsigned, so |−2^(ANCHO-1)| = 2^(ANCHO-1) is representable and needs no special case.
- The product always fits in DOBLEANCHO bits; the block itself never overflows. Range reduction is the downstream stage's job.
- inicio while listo=0: ignored, operands not sampled. No queuing.
- inicio in the cycle valido=1 (state REPOSO): accepted; a back-to-back operation starts.
- Operand changes while busy have no effect.
- A zero operand still takes the full ANCHO+2 cycles. No early termination, so latency is deterministic.
- The counter is sized clog2(ANCHO+1) bits and does not wrap within one operation.

Decomposition:
- Shared header (constantes.h): ANCHO, RESOLUCION, DOBLEANCHO defaults and the state encoding localparams (REPOSO, CALCULO, AJUSTE, 2-bit).
- Module body: FSM, counter and datapath (magnitude, shift-add, final negation) in one module.
- Natural optional sub-module: valor_absoluto (ANCHO-bit two's-complement magnitude). It is reused for both operands.

Test Plan:
1. Reset then idle: reset_n=0 mid-CALCULO → producto=0, valido=0, listo=1 immediately; no valido after release.
2. 1.5×2.0: A=0x0180, B=0x0200, inicio pulse → valido after exactly 17 edges, producto=0x00030000; listo low for 17 cycles.
3. Sign handling: A=0xFE80 (−1.5), B=0x0200 → producto=0xFFFD0000. Swap operands → same result. −1.5×−2.0 (0xFE80, 0xFE00) → 0x00030000.
4. Extremes: 0x8000×0x8000 → 0x40000000 (the truncator must then saturate to 0x7FFF); 0x7FFF×0x8000 → 0xC0008000; 0x0000×0x8000 → 0x00000000 with full latency.
5. Handshake: inicio held high throughout with new operands while busy → only the first pair is computed. Inicio in the valido cycle → the second result arrives 17 edges later, with no idle gap.
6. Random sweep: 1000 random signed pairs. Scoreboard compares against the $signed(A)*$signed(B) reference. Check valido is single-cycle and producto is stable between valido pulses.
